huff_sym_decode: RTL and testbench



---
 rtl/huff_sym_decode.sv | 225 ++++++++++++++++++++++
 tb/tb_huff_sym_decode.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huff_sym_decode.sv
// Table-driven Huffman symbol decoder for an LSB-first deflate byte stream.
// Define HUFF_SYM_DECODE_RAW_EN to add the raw-bit extraction port.
module huff_sym_decode #(
  parameter int HUFF_CODE_LEN = 8,
  parameter int HUFF_LEN_LEN  = 4,
  parameter int SYM_W         = 5,
  parameter int BUF_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     dec_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic                     tbl_rd,
  output logic [HUFF_CODE_LEN-1:0] tbl_addr,
  input  logic [SYM_W-1:0]         tbl_sym,
  input  logic [HUFF_LEN_LEN-1:0]  tbl_len,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic [SYM_W-1:0]         sym_data,
  output logic [HUFF_LEN_LEN-1:0]  sym_len,
  output logic [4:0]               bit_cnt,
  output logic                     eos,
  output logic                     err
`ifdef HUFF_SYM_DECODE_RAW_EN
  ,
  input  logic                     raw_req,
  input  logic [3:0]               raw_nbits,
  output logic [7:0]               raw_data,
  output logic                     raw_valid
`endif
);

  localparam logic [4:0] CODE_LEN_C = 5'(HUFF_CODE_LEN);
  localparam logic [4:0] IN_LIMIT_C = 5'(BUF_W - 8);

  typedef enum logic [2:0] {IDLE, LOOKUP, RESOLVE, OUT, ERR} state_e;

  state_e                   state_q, state_d;
  logic [BUF_W-1:0]         buf_q, buf_d;
  logic [4:0]               bit_cnt_q, bit_cnt_d;
  logic                     last_seen_q, last_seen_d;
  logic                     err_q, err_d;
  logic                     tbl_rd_q, tbl_rd_d;
  logic [HUFF_CODE_LEN-1:0] tbl_addr_q, tbl_addr_d;
  logic                     sym_valid_q, sym_valid_d;
  logic [SYM_W-1:0]         sym_data_q, sym_data_d;
  logic [HUFF_LEN_LEN-1:0]  sym_len_q, sym_len_d;

  logic                     accept;
  logic                     can_decode;
  logic                     raw_pending;
  logic [4:0]               shamt;
  logic [4:0]               cnt_sh;
  logic [BUF_W-1:0]         buf_sh;
  logic [HUFF_CODE_LEN-1:0] addr_rev;

`ifdef HUFF_SYM_DECODE_RAW_EN
  logic [7:0] raw_data_q, raw_data_d;
  logic       raw_valid_q, raw_valid_d;
  assign raw_pending = raw_req;
  assign raw_data    = raw_data_q;
  assign raw_valid   = raw_valid_q;
`else
  assign raw_pending = 1'b0;
`endif

  assign in_ready   = (bit_cnt_q <= IN_LIMIT_C) & ~last_seen_q & ~err_q;
  assign accept     = in_valid & in_ready;
  assign can_decode = dec_en & ((bit_cnt_q >= CODE_LEN_C) |
                                (last_seen_q & (bit_cnt_q != 5'd0)));

  // First stream bit becomes the address MSB; bits above bit_cnt are kept zero.
  always_comb begin
    for (int i = 0; i < HUFF_CODE_LEN; i++) begin
      addr_rev[HUFF_CODE_LEN-1-i] = buf_q[i];
    end
  end

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through this block can infer a latch.
    state_d     = state_q;
    last_seen_d = last_seen_q;
    err_d       = err_q;
    tbl_rd_d    = 1'b0;
    tbl_addr_d  = tbl_addr_q;
    sym_valid_d = sym_valid_q;
    sym_data_d  = sym_data_q;
    sym_len_d   = sym_len_q;
`ifdef HUFF_SYM_DECODE_RAW_EN
    raw_valid_d = raw_valid_q;
    raw_data_d  = raw_data_q;
`endif
    shamt       = 5'd0;

    case (state_q)
      IDLE: begin
`ifdef HUFF_SYM_DECODE_RAW_EN
        if (raw_req) begin
          if (bit_cnt_q >= 5'(raw_nbits)) begin
            shamt       = 5'(raw_nbits);
            raw_data_d  = buf_q[7:0] & ~(8'hFF << raw_nbits);
            raw_valid_d = 1'b1;
            state_d     = OUT;
          end else if (last_seen_q) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end else
`endif
        if (can_decode) begin
          tbl_rd_d   = 1'b1;
          tbl_addr_d = addr_rev;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: state_d = RESOLVE;
      RESOLVE: begin
        sym_data_d = tbl_sym;
        sym_len_d  = tbl_len;
        if ((tbl_len == '0) || (5'(tbl_len) > bit_cnt_q)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          shamt       = 5'(tbl_len);
          sym_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (sym_ready) begin
          sym_valid_d = 1'b0;
`ifdef HUFF_SYM_DECODE_RAW_EN
          raw_valid_d = 1'b0;
`endif
          if (can_decode && !raw_pending) begin
            tbl_rd_d   = 1'b1;
            tbl_addr_d = addr_rev;
            state_d    = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase

    // A byte landing in the same cycle as a shift goes right above the surviving bits.
    buf_sh    = buf_q >> shamt;
    cnt_sh    = bit_cnt_q - shamt;
    buf_d     = buf_sh;
    bit_cnt_d = cnt_sh;
    if (accept) begin
      buf_d     = buf_sh | (BUF_W'(in_data) << cnt_sh);
      bit_cnt_d = cnt_sh + 5'd8;
      if (in_last) last_seen_d = 1'b1;
    end

    if (clr) begin
      state_d     = IDLE;
      buf_d       = '0;
      bit_cnt_d   = 5'd0;
      last_seen_d = 1'b0;
      err_d       = 1'b0;
      tbl_rd_d    = 1'b0;
      tbl_addr_d  = '0;
      sym_valid_d = 1'b0;
      sym_data_d  = '0;
      sym_len_d   = '0;
`ifdef HUFF_SYM_DECODE_RAW_EN
      raw_valid_d = 1'b0;
      raw_data_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      bit_cnt_q   <= 5'd0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
      tbl_rd_q    <= 1'b0;
      tbl_addr_q  <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      sym_len_q   <= '0;
`ifdef HUFF_SYM_DECODE_RAW_EN
      raw_valid_q <= 1'b0;
      raw_data_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking here so every flop updates from the same pre-edge values.
      state_q     <= state_d;
      buf_q       <= buf_d;
      bit_cnt_q   <= bit_cnt_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
      tbl_rd_q    <= tbl_rd_d;
      tbl_addr_q  <= tbl_addr_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      sym_len_q   <= sym_len_d;
`ifdef HUFF_SYM_DECODE_RAW_EN
      raw_valid_q <= raw_valid_d;
      raw_data_q  <= raw_data_d;
`endif
    end
  end

  assign tbl_rd    = tbl_rd_q;
  assign tbl_addr  = tbl_addr_q;
  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign sym_len   = sym_len_q;
  assign bit_cnt   = bit_cnt_q;
  assign err       = err_q;
  assign eos       = last_seen_q & (bit_cnt_q == 5'd0) & (state_q == IDLE);

endmodule

// File: tb/tb_huff_sym_decode.sv
// Directed bench for huff_sym_decode: a synchronous lookup-table model plus
// hand-computed symbol sequences, stall, error, dec_en, reset and merge cases.
module tb_huff_sym_decode;

  logic       clk, rst_n, clr, dec_en;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       tbl_rd;
  logic [7:0] tbl_addr;
  logic [4:0] tbl_sym = '0;
  logic [3:0] tbl_len = '0;
  logic       sym_valid, sym_ready;
  logic [4:0] sym_data;
  logic [3:0] sym_len;
  logic [4:0] bit_cnt;
  logic       eos, err;
`ifdef HUFF_SYM_DECODE_RAW_EN
  logic       raw_req;
  logic [3:0] raw_nbits;
  logic [7:0] raw_data;
  logic       raw_valid;
`endif

  huff_sym_decode dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .dec_en(dec_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .tbl_rd(tbl_rd), .tbl_addr(tbl_addr), .tbl_sym(tbl_sym), .tbl_len(tbl_len),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_data(sym_data), .sym_len(sym_len),
    .bit_cnt(bit_cnt), .eos(eos), .err(err)
`ifdef HUFF_SYM_DECODE_RAW_EN
    , .raw_req(raw_req), .raw_nbits(raw_nbits), .raw_data(raw_data), .raw_valid(raw_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table memory with one-cycle registered read.
  logic [4:0] mem_sym [256];
  logic [3:0] mem_len [256];
  int         rd_cnt = 0;
  always @(posedge clk) begin
    if (tbl_rd) begin
      tbl_sym <= mem_sym[tbl_addr];
      tbl_len <= mem_len[tbl_addr];
      rd_cnt  <= rd_cnt + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // kind 0: 0xxxxxxx->sym0/1, 10xxxxxx->sym1/2, 11xxxxxx->sym2/2
  // kind 1: same but the 11xxxxxx entries are empty; kind 2: all length 8
  task automatic load_table(input int kind);
    logic [7:0] ab;
    for (int a = 0; a < 256; a++) begin
      ab = 8'(a);
      if (kind == 2) begin
        mem_sym[a] = ab[7:3] ^ ab[4:0];
        mem_len[a] = 4'd8;
      end else if (a < 128) begin
        mem_sym[a] = 5'd0; mem_len[a] = 4'd1;
      end else if (a < 192) begin
        mem_sym[a] = 5'd1; mem_len[a] = 4'd2;
      end else begin
        mem_sym[a] = 5'd2; mem_len[a] = (kind == 1) ? 4'd0 : 4'd2;
      end
    end
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Presents a byte until accepted; returns on the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && g < 200) begin @(negedge clk); g++; end
    if (!in_ready) check("send_byte accept timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get_sym(output logic [4:0] s, output logic [3:0] l, output logic ok);
    int g = 0;
    while (!sym_valid && g < 100) begin @(negedge clk); g++; end
    ok = sym_valid;
    s  = sym_data;
    l  = sym_len;
  endtask

  task automatic wait_tbl_rd(output logic ok);
    int g = 0;
    while (!tbl_rd && g < 50) begin @(negedge clk); g++; end
    ok = tbl_rd;
  endtask

  // Field order: data, nsym, syms[0:7], lens[0:7], exp_err (symbol 0 leftmost).
  typedef struct packed {
    logic [7:0]      data;
    logic [3:0]      nsym;
    logic [0:7][4:0] syms;
    logic [0:7][3:0] lens;
    logic            exp_err;
  } vec_t;

  vec_t vecs [6];
  logic [0:5][4:0] pat_s = {5'd1, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0};
  logic [0:5][3:0] pat_l = {4'd2, 4'd1, 4'd2, 4'd1, 4'd1, 4'd1};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] s;
    logic [3:0] l;
    logic       ok, seen, stable;
    int         r0;

    vecs[0] = {8'h19, 4'd6, {5'd1,5'd0,5'd2,5'd0,5'd0,5'd0,5'd0,5'd0},
               {4'd2,4'd1,4'd2,4'd1,4'd1,4'd1,4'd0,4'd0}, 1'b0};
    vecs[1] = {8'h00, 4'd8, {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0},
               {4'd1,4'd1,4'd1,4'd1,4'd1,4'd1,4'd1,4'd1}, 1'b0};
    vecs[2] = {8'hFF, 4'd4, {5'd2,5'd2,5'd2,5'd2,5'd0,5'd0,5'd0,5'd0},
               {4'd2,4'd2,4'd2,4'd2,4'd0,4'd0,4'd0,4'd0}, 1'b0};
    vecs[3] = {8'h05, 4'd6, {5'd1,5'd1,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0},
               {4'd2,4'd2,4'd1,4'd1,4'd1,4'd1,4'd0,4'd0}, 1'b0};
    // Final lone '1' looks up a 2-bit code with only 1 bit left.
    vecs[4] = {8'h80, 4'd7, {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0},
               {4'd1,4'd1,4'd1,4'd1,4'd1,4'd1,4'd1,4'd0}, 1'b1};
    // Last code exactly uses the remaining 2 bits.
    vecs[5] = {8'h40, 4'd7, {5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd1,5'd0},
               {4'd1,4'd1,4'd1,4'd1,4'd1,4'd1,4'd2,4'd0}, 1'b0};

    rst_n = 1'b0; clr = 1'b0; dec_en = 1'b1; sym_ready = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
`ifdef HUFF_SYM_DECODE_RAW_EN
    raw_req = 1'b0; raw_nbits = 4'd0;
`endif
    load_table(0);
    repeat (3) @(negedge clk);
    check("reset sym_valid", 32'(sym_valid), 32'd0);
    check("reset tbl_rd",    32'(tbl_rd),    32'd0);
    check("reset tbl_addr",  32'(tbl_addr),  32'd0);
    check("reset sym_data",  32'(sym_data),  32'd0);
    check("reset sym_len",   32'(sym_len),   32'd0);
    check("reset bit_cnt",   32'(bit_cnt),   32'd0);
    check("reset eos",       32'(eos),       32'd0);
    check("reset err",       32'(err),       32'd0);
    rst_n = 1'b1;

    // Single-byte streams with in_last, consumer always ready.
    for (int v = 0; v < 6; v++) begin
      do_clr();
      send_byte(vecs[v].data, 1'b1);
      for (int j = 0; j < int'(vecs[v].nsym); j++) begin
        get_sym(s, l, ok);
        check($sformatf("v%0d sym%0d valid", v, j), 32'(ok), 32'd1);
        check($sformatf("v%0d sym%0d data", v, j), 32'(s), 32'(vecs[v].syms[j]));
        check($sformatf("v%0d sym%0d len", v, j), 32'(l), 32'(vecs[v].lens[j]));
        @(negedge clk);
      end
      repeat (6) @(negedge clk);
      if (vecs[v].exp_err) begin
        check($sformatf("v%0d err", v), 32'(err), 32'd1);
        check($sformatf("v%0d in_ready", v), 32'(in_ready), 32'd0);
        check($sformatf("v%0d sym_valid", v), 32'(sym_valid), 32'd0);
      end else begin
        check($sformatf("v%0d eos", v), 32'(eos), 32'd1);
        check($sformatf("v%0d bit_cnt", v), 32'(bit_cnt), 32'd0);
        check($sformatf("v%0d err", v), 32'(err), 32'd0);
      end
    end

    // Four 0x19 bytes, first symbol held for 10 cycles.
    do_clr();
    sym_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 4; b++) send_byte(8'h19, b == 3);
      end
      begin
        logic [4:0] cs;
        logic [3:0] cl;
        logic       cok;
        for (int j = 0; j < 24; j++) begin
          get_sym(cs, cl, cok);
          check($sformatf("stall sym%0d valid", j), 32'(cok), 32'd1);
          check($sformatf("stall sym%0d data", j), 32'(cs), 32'(pat_s[j % 6]));
          check($sformatf("stall sym%0d len", j), 32'(cl), 32'(pat_l[j % 6]));
          if (j == 0) begin
            stable = 1'b1;
            for (int c = 0; c < 10; c++) begin
              @(negedge clk);
              if (!sym_valid || sym_data !== cs || sym_len !== cl) stable = 1'b0;
            end
            check("stall output stable", 32'(stable), 32'd1);
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall bit_cnt", 32'(bit_cnt), 32'd14);
            sym_ready = 1'b1;
          end
          @(negedge clk);
        end
      end
    join
    repeat (6) @(negedge clk);
    check("stall eos", 32'(eos), 32'd1);
    check("stall bit_cnt end", 32'(bit_cnt), 32'd0);

    // Empty table entry hit.
    load_table(1);
    do_clr();
    send_byte(8'hFF, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (sym_valid) seen = 1'b1;
    end
    check("empty err", 32'(err), 32'd1);
    check("empty in_ready", 32'(in_ready), 32'd0);
    check("empty no sym_valid", 32'(seen), 32'd0);
    check("empty bit_cnt", 32'(bit_cnt), 32'd8);
    do_clr();
    check("clr err", 32'(err), 32'd0);
    check("clr bit_cnt", 32'(bit_cnt), 32'd0);
    check("clr in_ready", 32'(in_ready), 32'd1);

    // Length-8 table; second byte accepted on the RESOLVE shift edge.
    load_table(2);
    do_clr();
    send_byte(8'h80, 1'b0);
    @(negedge clk);
    send_byte(8'h01, 1'b1);
    check("merge bit_cnt", 32'(bit_cnt), 32'd8);
    get_sym(s, l, ok);
    check("merge sym0 data", 32'(s), 32'h01);
    check("merge sym0 len", 32'(l), 32'd8);
    @(negedge clk);
    get_sym(s, l, ok);
    check("merge sym1 valid", 32'(ok), 32'd1);
    check("merge sym1 data", 32'(s), 32'h10);
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("merge eos", 32'(eos), 32'd1);
    check("merge bit_cnt end", 32'(bit_cnt), 32'd0);

    // dec_en gating and mid-symbol deassertion.
    load_table(0);
    do_clr();
    dec_en = 1'b0;
    send_byte(8'h19, 1'b1);
    r0 = rd_cnt;
    repeat (5) @(negedge clk);
    check("dec_en off no tbl_rd", 32'(rd_cnt - r0), 32'd0);
    check("dec_en off bit_cnt", 32'(bit_cnt), 32'd8);
    dec_en = 1'b1;
    wait_tbl_rd(ok);
    check("dec_en tbl_rd seen", 32'(ok), 32'd1);
    check("dec_en tbl_addr", 32'(tbl_addr), 32'h98);
    dec_en = 1'b0;
    get_sym(s, l, ok);
    check("dec_en sym data", 32'(s), 32'd1);
    check("dec_en sym len", 32'(l), 32'd2);
    @(negedge clk);
    r0 = rd_cnt;
    repeat (8) @(negedge clk);
    check("dec_en parked no tbl_rd", 32'(rd_cnt - r0), 32'd0);
    check("dec_en parked bit_cnt", 32'(bit_cnt), 32'd6);
    check("dec_en parked eos", 32'(eos), 32'd0);
    dec_en = 1'b1;
    for (int j = 1; j < 6; j++) begin
      get_sym(s, l, ok);
      check($sformatf("dec_en resume sym%0d", j), 32'(s), 32'(pat_s[j]));
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("dec_en resume eos", 32'(eos), 32'd1);

    // Asynchronous reset while a symbol waits in OUT.
    do_clr();
    sym_ready = 1'b0;
    send_byte(8'h19, 1'b1);
    get_sym(s, l, ok);
    check("areset pre sym_valid", 32'(ok), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("areset sym_valid", 32'(sym_valid), 32'd0);
    check("areset err", 32'(err), 32'd0);
    check("areset bit_cnt", 32'(bit_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sym_ready = 1'b1;

`ifdef HUFF_SYM_DECODE_RAW_EN
    do_clr();
    dec_en = 1'b0; sym_ready = 1'b0;
    raw_req = 1'b1; raw_nbits = 4'd3;
    send_byte(8'hA5, 1'b1);
    begin
      int g = 0;
      while (!raw_valid && g < 50) begin @(negedge clk); g++; end
    end
    check("raw valid", 32'(raw_valid), 32'd1);
    check("raw data", 32'(raw_data), 32'h05);
    check("raw bit_cnt", 32'(bit_cnt), 32'd5);
    check("raw no sym_valid", 32'(sym_valid), 32'd0);
    raw_req = 1'b0; sym_ready = 1'b1; dec_en = 1'b1;
    wait_tbl_rd(ok);
    check("raw then lookup", 32'(ok), 32'd1);
    check("raw lookup addr", 32'(tbl_addr), 32'h28);
    do_clr();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
